spi_shift_chain: RTL and testbench

Parametrised SPI master shift engine, the successor to the fixed-width shift register in the SPI core. It serialises a MAX_CHAR-wide word onto mosi and deserialises miso into the same register. The divider supplies sclk edge strobes and the Wishbone slave supplies byte-lane writes. New over the previous generation: a shadow TX buffer for back-to-back characters without an idle gap, a separate RX hold register, a done strobe, and abort.

---
 rtl/spi_shift_chain.sv | 173 +++++++++++++++++
 tb/tb_spi_shift_chain.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_chain.sv
// SPI master shift engine: serialises/deserialises a MAX_CHAR-bit word, with a
// shadow TX buffer for chained characters, an RX hold register, done strobe and abort.
module spi_shift_chain #(
    parameter  int unsigned MAX_CHAR = 32,
    localparam int unsigned CLB      = $clog2(MAX_CHAR),
    localparam int unsigned LW       = (MAX_CHAR / 32 > 1) ? MAX_CHAR / 32 : 1
) (
    input  logic                wb_clk,
    input  logic                wb_reset,
    input  logic                go,
    input  logic                abort,
    input  logic [CLB-1:0]      len,
    input  logic                lsb,
    input  logic                tx_negedge,
    input  logic                rx_negedge,
    input  logic                sclk_pos,
    input  logic                sclk_neg,
    input  logic [LW-1:0]       latch,
    input  logic [3:0]          byte_sel,
    input  logic [31:0]         p_in,
    input  logic                miso,
    output logic                mosi,
    output logic                tip,
    output logic                last,
    output logic                done,
    output logic [MAX_CHAR-1:0] p_out
);

    localparam int unsigned NLANE = MAX_CHAR / 8;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MAX_CHAR-1:0] r_data;
    logic [MAX_CHAR-1:0] r_shadow;
    logic [MAX_CHAR-1:0] r_rx_hold;
    logic                r_pend;
    logic                r_mosi;
    logic                r_done;
    logic [CLB:0]        r_tcnt;
    logic [CLB:0]        r_rcnt;

    logic [CLB:0]        w_len_eff;
    logic [CLB:0]        w_tpos;
    logic [CLB:0]        w_rpos;
    logic                w_txe;
    logic                w_rxe;
    logic                w_end;
    logic                w_tx_fire;
    logic                w_rx_fire;
    logic                w_reload;
    logic                w_wr_any;
    logic [LW-1:0]       w_word_hit;
    logic [MAX_CHAR-1:0] w_wr_mask;
    logic [MAX_CHAR-1:0] w_wr_data;

    assign w_len_eff = (len == '0) ? (CLB+1)'(MAX_CHAR) : {1'b0, len};
    assign w_txe     = tx_negedge ? sclk_neg : sclk_pos;
    assign w_rxe     = rx_negedge ? sclk_neg : sclk_pos;
    assign w_tpos    = lsb ? (w_len_eff - r_tcnt) : (r_tcnt - (CLB+1)'(1));
    assign w_rpos    = lsb ? (w_len_eff - r_rcnt) : (r_rcnt - (CLB+1)'(1));

    // Lowest set latch bit selects the 32-bit word; lanes past MAX_CHAR do not exist.
    assign w_word_hit = latch & (~latch + LW'(1));

    always_comb begin
        w_wr_mask = '0;
        w_wr_data = '0;
        for (int j = 0; j < NLANE; j++) begin
            if (w_word_hit[j/4] && byte_sel[j%4]) begin
                w_wr_mask[8*j +: 8] = 8'hFF;
                w_wr_data[8*j +: 8] = p_in[8*(j%4) +: 8];
            end
        end
    end

    assign w_wr_any = |w_wr_mask;

    // Next-state and shift-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_end       = 1'b0;
        w_tx_fire   = 1'b0;
        w_rx_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go && !abort) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == '0 && r_rcnt == '0) begin
                    w_end = 1'b1;
                    if (!r_pend) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tx_fire = w_txe && (r_tcnt != '0);
                    w_rx_fire = w_rxe && (r_rcnt != '0);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_reload = (r_state == S_IDLE) || abort || (w_end && r_pend);

    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_shadow  <= '0;
            r_rx_hold <= '0;
            r_pend    <= 1'b0;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
            r_tcnt    <= '0;
            r_rcnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_end;
            if (w_end) begin
                r_rx_hold <= r_data;
            end

            if (w_reload) begin
                r_tcnt <= w_len_eff;
                r_rcnt <= w_len_eff;
            end else begin
                if (w_tx_fire) r_tcnt <= r_tcnt - (CLB+1)'(1);
                if (w_rx_fire) r_rcnt <= r_rcnt - (CLB+1)'(1);
            end

            if (w_tx_fire) begin
                r_mosi <= r_data[w_tpos[CLB-1:0]];
            end

            // Idle writes target the live word; in-flight writes queue in the shadow.
            if (r_state == S_IDLE) begin
                r_data <= (r_data & ~w_wr_mask) | (w_wr_data & w_wr_mask);
            end else if (w_end && r_pend) begin
                r_data <= r_shadow;
            end else if (w_rx_fire) begin
                r_data[w_rpos[CLB-1:0]] <= miso;
            end

            if (r_state == S_SHIFT) begin
                r_shadow <= (r_shadow & ~w_wr_mask) | (w_wr_data & w_wr_mask);
            end

            if (abort) begin
                r_pend <= 1'b0;
            end else if (r_state == S_SHIFT && w_wr_any) begin
                r_pend <= 1'b1;
            end else if (w_end) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign tip   = (r_state == S_SHIFT);
    assign last  = tip && (r_tcnt == '0);
    assign mosi  = r_mosi;
    assign done  = r_done;
    assign p_out = r_rx_hold;

endmodule

// File: tb/tb_spi_shift_chain.sv
// Directed bench for spi_shift_chain (MAX_CHAR=32): loopback shifting, chaining,
// abort and asynchronous reset.
module tb_spi_shift_chain;

    logic        clk;
    logic        wb_reset;
    logic        go;
    logic        abort;
    logic [4:0]  len;
    logic        lsb;
    logic        tx_negedge;
    logic        rx_negedge;
    logic        sclk_pos;
    logic        sclk_neg;
    logic [0:0]  latch;
    logic [3:0]  byte_sel;
    logic [31:0] p_in;
    logic        miso;
    logic        mosi;
    logic        tip;
    logic        last;
    logic        done;
    logic [31:0] p_out;

    logic        miso_one;
    logic        chain_mon;
    logic        early_last;
    logic        final_last;
    logic [63:0] seq;
    logic [63:0] seq2;
    int          n_checks;
    int          n_errors;
    int          done_cnt;
    int          gap_cnt;
    int          d0;
    logic [31:0] pq[$];

    spi_shift_chain #(.MAX_CHAR(32)) dut (
        .wb_clk(clk), .wb_reset(wb_reset), .go(go), .abort(abort), .len(len),
        .lsb(lsb), .tx_negedge(tx_negedge), .rx_negedge(rx_negedge),
        .sclk_pos(sclk_pos), .sclk_neg(sclk_neg), .latch(latch), .byte_sel(byte_sel),
        .p_in(p_in), .miso(miso), .mosi(mosi), .tip(tip), .last(last), .done(done),
        .p_out(p_out)
    );

    assign miso = miso_one ? 1'b1 : mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            pq.push_back(p_out);
        end
        if (chain_mon && !tip) gap_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        latch = 1'b1; byte_sel = 4'hF; p_in = d;
        tick();
        latch = 1'b0; byte_sel = 4'h0; p_in = '0;
    endtask

    task automatic start();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // One sclk period: falling strobe (drive), then rising strobe (sample).
    task automatic run_bits(input int n, output logic [63:0] s);
        s = '0;
        early_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            sclk_neg = 1'b1;
            tick();
            sclk_neg = 1'b0;
            s = {s[62:0], mosi};
            if (i < n - 1) early_last = early_last | last;
            else final_last = last;
            tick();
            sclk_pos = 1'b1;
            tick();
            sclk_pos = 1'b0;
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && tip; i++) tick();
        check(tag, tip, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; done_cnt = 0; gap_cnt = 0;
        go = 0; abort = 0; len = 5'd8; lsb = 0; tx_negedge = 1; rx_negedge = 0;
        sclk_pos = 0; sclk_neg = 0; latch = 0; byte_sel = 0; p_in = 0;
        miso_one = 0; chain_mon = 0; early_last = 0; final_last = 0;
        wb_reset = 1'b1;
        #1;
        check("rst_mosi", mosi, 1'b0);
        check("rst_tip", tip, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pout", p_out, 32'h0);
        tick(); tick();
        wb_reset = 1'b0;
        tick();

        // MSB first, loopback 0xA5
        wr(32'h0000_00A5);
        start();
        run_bits(8, seq);
        wait_idle("t1_idle");
        check("t1_seq", seq, 64'hA5);
        check("t1_done", done_cnt, 1);
        check("t1_pout", p_out, 32'h0000_00A5);

        // LSB first, 0x01
        lsb = 1'b1;
        wr(32'h0000_0001);
        start();
        run_bits(8, seq);
        wait_idle("t2_idle");
        check("t2_seq", seq, 64'h80);
        check("t2_done", done_cnt, 2);
        check("t2_pout", p_out, 32'h0000_0001);

        // Full 32-bit character, miso tied high
        lsb = 1'b0; len = 5'd0; miso_one = 1'b1;
        wr(32'hDEAD_BEEF);
        start();
        run_bits(32, seq);
        check("t3_early_last", early_last, 1'b0);
        check("t3_last", final_last, 1'b1);
        wait_idle("t3_idle");
        check("t3_seq", seq, 64'hDEAD_BEEF);
        check("t3_pout", p_out, 32'hFFFF_FFFF);
        check("t3_done", done_cnt, 3);
        miso_one = 1'b0; len = 5'd8;

        // Chained characters via shadow write
        pq.delete();
        wr(32'h0000_00C3);
        start();
        chain_mon = 1'b1;
        wr(32'h0000_003C);
        run_bits(8, seq);
        run_bits(8, seq2);
        chain_mon = 1'b0;
        wait_idle("t4_idle");
        check("t4_seq_a", seq, 64'hC3);
        check("t4_seq_b", seq2, 64'h3C);
        check("t4_gap", gap_cnt, 0);
        check("t4_done", done_cnt, 5);
        check("t4_n_pq", pq.size(), 2);
        if (pq.size() == 2) begin
            check("t4_pout_a", pq[0], 32'h0000_00C3);
            check("t4_pout_b", pq[1], 32'h0000_003C);
        end

        // Abort after three bits, then a fresh character
        wr(32'h0000_00A5);
        start();
        run_bits(3, seq);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_tip", tip, 1'b0);
        check("t5_mosi", mosi, 1'b1);
        tick(); tick(); tick();
        check("t5_nodone", done_cnt, d0);
        check("t5_pout_keep", p_out, 32'h0000_003C);
        start();
        run_bits(8, seq);
        wait_idle("t5_idle");
        check("t5_seq", seq, 64'hA5);
        check("t5_pout", p_out, 32'h0000_00A5);
        check("t5_done", done_cnt, d0 + 1);

        // Asynchronous reset mid-character with a pending shadow write
        start();
        wr(32'h0000_0077);
        run_bits(3, seq);
        wb_reset = 1'b1;
        #1;
        check("t6_mosi", mosi, 1'b0);
        check("t6_tip", tip, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_last", last, 1'b0);
        check("t6_pout", p_out, 32'h0);
        tick();
        wb_reset = 1'b0;
        tick();
        d0 = done_cnt;
        wr(32'h0000_005A);
        start();
        run_bits(8, seq);
        wait_idle("t6_idle");
        check("t6_seq", seq, 64'h5A);
        check("t6_pout2", p_out, 32'h0000_005A);
        check("t6_done_once", done_cnt, d0 + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
